// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: registered-grant arbiter sharing one Wishbone RAM between imem and dmem
module wb_mem_arbiter #(
  parameter int TIMEOUT = 255,
  parameter bit FAIR    = 1
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic        imem_stb_i,
  input  logic [31:0] imem_adr_i,
  output logic [31:0] imem_dat_o,
  output logic        imem_ack_o,
  input  logic        dmem_stb_i,
  input  logic        dmem_we_i,
  input  logic [3:0]  dmem_be_i,
  input  logic [31:0] dmem_adr_i,
  input  logic [31:0] dmem_dat_i,
  output logic [31:0] dmem_dat_o,
  output logic        dmem_ack_o,
  output logic        mem_cyc_o,
  output logic        mem_stb_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_adr_o,
  output logic [31:0] mem_dat_o,
  input  logic [31:0] mem_dat_i,
  input  logic        mem_ack_i,
  output logic        tout_o
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CLAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CMAX  = CW'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
  state_t        state, state_nx;
  logic          last_r;
  logic [CW-1:0] cnt;
  logic          gi, gd, gnt, stb_g, tmo, ack_g, pick_i;
  always_comb begin
    gi       = state == GNT_I;
    gd       = state == GNT_D;
    gnt      = gi | gd;
    stb_g    = gi ? imem_stb_i : dmem_stb_i;
    tmo      = TIMEOUT != 0 && gnt && !mem_ack_i && cnt == CLAST;
    ack_g    = gnt && (mem_ack_i || tmo);
    // last_r=1 means dmem won the previous grant, so imem goes first on a tie
    pick_i   = imem_stb_i && (!dmem_stb_i || (FAIR && last_r));
    state_nx = gnt ? ((ack_g || !stb_g) ? IDLE : state) :
               pick_i ? GNT_I : dmem_stb_i ? GNT_D : IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state  <= IDLE;
      last_r <= 1'b1;
      cnt    <= '0;
      tout_o <= 1'b0;
    end else begin
      state  <= state_nx;
      if (!gnt && state_nx != IDLE) last_r <= state_nx == GNT_D;
      cnt    <= !gnt ? '0 : (!mem_ack_i && cnt != CMAX) ? cnt + 1'b1 : cnt;
      tout_o <= tout_o | tmo;
    end
  end
  assign mem_cyc_o  = gnt;
  assign mem_stb_o  = gnt;
  assign mem_we_o   = gd & dmem_we_i;
  assign mem_be_o   = gd ? dmem_be_i : {4{gi}};
  assign mem_adr_o  = gd ? dmem_adr_i : gi ? imem_adr_i : '0;
  assign mem_dat_o  = gd ? dmem_dat_i : '0;
  assign imem_ack_o = gi & ack_g;
  assign dmem_ack_o = gd & ack_g;
  assign imem_dat_o = tmo ? '0 : mem_dat_i;
  assign dmem_dat_o = tmo ? '0 : mem_dat_i;
endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb_wb_mem_arbiter: scoreboard bench for the arbiter with a latency-1 RAM model
module tb_wb_mem_arbiter;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic        i_stb = 0, d_stb = 0, d_we = 0;
  logic [31:0] i_adr = 0, d_adr = 0, d_wdat = 0;
  logic [3:0]  d_be = 0;
  logic [31:0] i_rdat, d_rdat, m_adr, m_wdat, m_rdat;
  logic        i_ack, d_ack, m_cyc, m_stb, m_we, m_ack, tout;
  logic [3:0]  m_be;
  logic        ram_on = 1, wd;
  logic [31:0] w40;
  wb_mem_arbiter #(.TIMEOUT(4), .FAIR(1)) u0 (
    .clk_i(clk), .rst_in(rst_n),
    .imem_stb_i(i_stb), .imem_adr_i(i_adr), .imem_dat_o(i_rdat), .imem_ack_o(i_ack),
    .dmem_stb_i(d_stb), .dmem_we_i(d_we), .dmem_be_i(d_be), .dmem_adr_i(d_adr),
    .dmem_dat_i(d_wdat), .dmem_dat_o(d_rdat), .dmem_ack_o(d_ack),
    .mem_cyc_o(m_cyc), .mem_stb_o(m_stb), .mem_we_o(m_we), .mem_be_o(m_be),
    .mem_adr_o(m_adr), .mem_dat_o(m_wdat), .mem_dat_i(m_rdat), .mem_ack_i(m_ack),
    .tout_o(tout));
  logic        f_i = 0, f_d = 0;
  logic [31:0] f_idat, f_ddat, f_adr, f_wdat;
  logic        f_iack, f_dack, f_cyc, f_stb, f_we, f_tout;
  logic [3:0]  f_be;
  wb_mem_arbiter #(.TIMEOUT(0), .FAIR(0)) u1 (
    .clk_i(clk), .rst_in(rst_n),
    .imem_stb_i(f_i), .imem_adr_i(32'h200), .imem_dat_o(f_idat), .imem_ack_o(f_iack),
    .dmem_stb_i(f_d), .dmem_we_i(1'b0), .dmem_be_i(4'hF), .dmem_adr_i(32'h300),
    .dmem_dat_i(32'h0), .dmem_dat_o(f_ddat), .dmem_ack_o(f_dack),
    .mem_cyc_o(f_cyc), .mem_stb_o(f_stb), .mem_we_o(f_we), .mem_be_o(f_be),
    .mem_adr_o(f_adr), .mem_dat_o(f_wdat), .mem_dat_i(32'h0), .mem_ack_i(f_cyc),
    .tout_o(f_tout));
  // RAM acks in the second grant cycle; 0x100 reads 0x13, 0x40 is the one writable word
  assign m_ack  = ram_on & m_cyc & wd;
  assign m_rdat = m_adr == 32'h100 ? 32'h13 : m_adr == 32'h40 ? w40 : ~m_adr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd  <= 1'b0;
      w40 <= 32'h1234_5678;
    end else begin
      wd <= m_cyc & ~m_ack;
      if (m_ack && m_we && m_adr == 32'h40)
        for (int b = 0; b < 4; b++) if (m_be[b]) w40[8*b +: 8] <= m_wdat[8*b +: 8];
    end
  end
  int errors = 0, checks = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  typedef struct {logic d; logic [31:0] dat;} exp_t;
  exp_t q[$];
  initial begin
    exp_t e;
    logic prev_ack = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_ack = 0;
      else begin
        if (prev_ack) chk("bubble", {31'b0, m_cyc}, 32'h0);
        if (i_ack || d_ack) begin
          chk("one_ack", {31'b0, i_ack & d_ack}, 32'h0);
          if (q.size() == 0) chk("unexpected_ack", {30'b0, i_ack, d_ack}, 32'h0);
          else begin
            e = q.pop_front();
            chk("ack_port", {31'b0, d_ack}, {31'b0, e.d});
            chk("ack_data", e.d ? d_rdat : i_rdat, e.dat);
          end
        end
        prev_ack = i_ack | d_ack;
      end
    end
  end
  task automatic push(input logic d, input logic [31:0] dat);
    exp_t e;
    e.d = d;
    e.dat = dat;
    q.push_back(e);
  endtask
  task automatic i_req(input logic [31:0] a, output int n);
    i_stb = 1; i_adr = a; n = 0;
    do begin @(negedge clk); n++; end while (!i_ack && n < 50);
    @(posedge clk); #1 i_stb = 0;
  endtask
  task automatic d_req(input logic we, input logic [3:0] be, input logic [31:0] a,
                       input logic [31:0] wdat, output int n);
    d_stb = 1; d_we = we; d_be = be; d_adr = a; d_wdat = wdat; n = 0;
    do begin @(negedge clk); n++; end while (!d_ack && n < 50);
    @(posedge clk); #1 d_stb = 0; d_we = 0;
  endtask
  initial begin
    #200000 $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    int n, n2, cnt;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cyc", {31'b0, m_cyc}, 0);
    chk("rst_ack", {30'b0, i_ack, d_ack}, 0);
    chk("rst_tout", {31'b0, tout}, 0);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    push(0, 32'h13);
    fork
      i_req(32'h100, n);
      begin
        @(negedge clk); chk("lat_idle", {31'b0, m_cyc}, 0);
        @(negedge clk); chk("lat_cyc", {31'b0, m_cyc & m_stb}, 1);
        chk("gi_adr", m_adr, 32'h100);
        chk("gi_be", {28'b0, m_be}, 32'hF);
        chk("gi_we", {31'b0, m_we}, 0);
        chk("gi_dat", m_wdat, 0);
      end
    join
    chk("read_lat", n, 3);
    push(1, 32'h1234_5678);
    fork
      d_req(1, 4'b0011, 32'h40, 32'hA5A5, n);
      begin
        @(negedge clk); @(negedge clk);
        chk("wr_we", {31'b0, m_we}, 1);
        chk("wr_be", {28'b0, m_be}, 32'h3);
        chk("wr_adr", m_adr, 32'h40);
        chk("wr_dat", m_wdat, 32'hA5A5);
      end
    join
    chk("write_lat", n, 3);
    push(1, 32'h1234_A5A5);
    d_req(0, 4'hF, 32'h40, 0, n);
    push(0, 32'h13); push(1, 32'h1234_A5A5); push(0, 32'h13); push(1, 32'h1234_A5A5);
    fork
      begin i_req(32'h100, n); i_req(32'h100, n); end
      begin d_req(0, 4'hF, 32'h40, 0, n2); d_req(0, 4'hF, 32'h40, 0, n2); end
    join
    chk("rr_drained", q.size(), 0);
    ram_on = 0;
    push(0, 32'h0);
    i_req(32'h100, n);
    chk("tmo_lat", n, 5);
    @(negedge clk); chk("tout_set", {31'b0, tout}, 1);
    ram_on = 1;
    @(posedge clk); #1;
    push(0, 32'h13);
    i_req(32'h100, n);
    chk("post_tmo_lat", n, 3);
    chk("tout_sticky", {31'b0, tout}, 1);
    ram_on = 0;
    d_stb = 1; d_adr = 32'h40;
    @(negedge clk);
    @(posedge clk); #1 i_stb = 1; i_adr = 32'h100;
    @(negedge clk);
    chk("ab_cyc", {31'b0, m_cyc}, 1);
    chk("ab_adr", m_adr, 32'h40);
    @(posedge clk); #1 d_stb = 0;
    @(negedge clk); chk("ab_noack", {31'b0, d_ack}, 0);
    @(posedge clk); #1 ram_on = 1;
    @(negedge clk); chk("ab_drop", {31'b0, m_cyc}, 0);
    push(0, 32'h13);
    n = 0;
    do begin @(negedge clk); n++; end while (!i_ack && n < 20);
    chk("ab_pending_i", n, 2);
    @(posedge clk); #1 i_stb = 0;
    @(posedge clk); #1;
    d_stb = 1; d_we = 1; d_be = 4'hF; d_adr = 32'h40; d_wdat = 32'hDEAD;
    i_stb = 1; i_adr = 32'h100;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_we", {31'b0, m_cyc & m_we}, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_cyc", {31'b0, m_cyc | m_stb}, 0);
    chk("arst_we", {31'b0, m_we}, 0);
    chk("arst_ack", {30'b0, i_ack, d_ack}, 0);
    chk("arst_tout", {31'b0, tout}, 0);
    @(posedge clk); #3 rst_n = 1; d_we = 0;
    push(0, 32'h13); push(1, 32'h1234_5678);
    @(negedge clk); chk("rel_idle", {31'b0, m_cyc}, 0);
    @(negedge clk); chk("rel_first_i", m_adr, 32'h100);
    n = 0;
    while (!i_ack && n < 20) begin @(negedge clk); n++; end
    chk("rel_i_ack", {31'b0, i_ack}, 1);
    @(posedge clk); #1 i_stb = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!d_ack && n < 20);
    chk("rel_d_ack", {31'b0, d_ack}, 1);
    @(posedge clk); #1 d_stb = 0;
    f_i = 1; f_d = 1; cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("fix_no_i", {31'b0, f_iack}, 0);
      if (f_dack) cnt++;
    end
    chk("fix_d_count", cnt, 4);
    @(posedge clk); #1 f_d = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!f_iack && n < 20);
    chk("fix_i_after", {31'b0, f_iack}, 1);
    @(posedge clk); #1 f_i = 0;
    repeat (3) @(posedge clk);
    chk("sb_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_mem_arbiter.md
Name: wb_mem_arbiter

Overview:
- Arbitrates one single-port Wishbone RAM between the core's instruction port (read-only) and data port (read/write).
- Replaces the combinational stb-based mux in the SoC top with a registered grant FSM.
- Supports round-robin or fixed priority, abort handling, and a bus-timeout watchdog that keeps a dead slave from hanging the core.
- Sits between the core's imem/dmem master ports and the RAM slave.

Parameters:
TIMEOUT, 255, cycles in grant without mem_ack_i before forced termination; 0 disables the watchdog
FAIR, 1, 1 = round-robin on simultaneous requests; 0 = fixed dmem priority

Ports:
clk_i  in  1  clock
rst_in  in  1  asynchronous active-low reset
imem_stb_i  in  1  instruction request (held until ack)
imem_adr_i  in  32  instruction address
imem_dat_o  out  32  instruction read data
imem_ack_o  out  1  instruction ack
dmem_stb_i  in  1  data request (held until ack)
dmem_we_i  in  1  data write enable
dmem_be_i  in  4  data byte enables
dmem_adr_i  in  32  data address
dmem_dat_i  in  32  data write data
dmem_dat_o  out  32  data read data
dmem_ack_o  out  1  data ack
mem_cyc_o  out  1  RAM cycle
mem_stb_o  out  1  RAM strobe, always equal to mem_cyc_o
mem_we_o  out  1  RAM write enable
mem_be_o  out  4  RAM byte enables
mem_adr_o  out  32  RAM address
mem_dat_o  out  32  RAM write data
mem_dat_i  in  32  RAM read data
mem_ack_i  in  1  RAM ack
tout_o  out  1  sticky timeout flag

Behaviour:
- Reset (async, rst_in=0), effective immediately, including mid-transaction:
  - state=IDLE, last_r=D, cnt=0, tout_o=0
  - mem_cyc/stb/we=0, imem_ack/dmem_ack=0
  - The in-flight transfer is dropped with no ack.
- FSM states: IDLE, GNT_I, GNT_D.
- IDLE, request selection:
  - Only imem_stb_i set -> GNT_I. Only dmem_stb_i set -> GNT_D.
  - Both set, FAIR=1 -> grant the port not in last_r. Both set, FAIR=0 -> GNT_D.
  - last_r updates on every grant.
- Latency: a request sampled in cycle N drives mem_cyc_o=1 in cycle N+1.
- GNT_x: mem_cyc_o=mem_stb_o=1 and mem_adr_o = granted port's address.
  - GNT_D: mem_we_o=dmem_we_i, mem_be_o=dmem_be_i, mem_dat_o=dmem_dat_i.
  - GNT_I: mem_we_o=0, mem_be_o=4'hF, mem_dat_o=0.
- IDLE outputs: mem_cyc_o=0, mem_we_o=0, mem_adr_o=0, mem_be_o=0.
- Ack path (combinational, same cycle): granted port's ack = mem_ack_i; the ungranted port's ack is always 0.
  - After an ack: next state IDLE, giving exactly one idle bubble between transfers.
- Read data: imem_dat_o = dmem_dat_o = mem_dat_i, except during a timeout ack, when both are 0.
- Abort: in GNT_x, if the granted stb drops before ack -> mem_cyc_o drops the next cycle, state IDLE, no ack issued.
- Watchdog: cnt clears on entry to GNT_x and increments each GNT cycle with mem_ack_i=0.
  - When cnt == TIMEOUT-1 and mem_ack_i=0 (TIMEOUT != 0): assert the granted ack for one cycle with data 0, set tout_o=1, next state IDLE.
  - mem_ack_i arriving in that same cycle takes precedence: normal ack, tout_o unchanged.
- tout_o is cleared only by reset.
- A request that arrives while the other port is granted waits; it is granted first in the next IDLE when FAIR=1.
- cnt width is $clog2(TIMEOUT+1), minimum 1. cnt saturates and never wraps.

Test Plan:
- Lone read: imem_stb_i=1, adr=0x100, RAM acks 1 cycle after cyc with 0x00000013 -> mem_cyc_o rises at cycle 1; imem_ack_o=1 with imem_dat_o=0x13 at cycle 2; dmem_ack_o stays 0.
- Simultaneous: both stb held, FAIR=1, from reset -> grant order I,D,I,D with one idle cycle between grants; FAIR=0 -> D is granted every time while dmem_stb_i stays high.
- Write: dmem write adr=0x40, be=4'b0011, dat=0xA5A5 -> mem_we_o=1, mem_be_o=0x3, mem_adr_o=0x40 during GNT_D; mem_we_o=0 in all GNT_I cycles.
- Timeout: TIMEOUT=4, RAM never acks -> imem_ack_o=1 with data 0 on the 4th grant cycle; tout_o=1 and stays 1; the next request is serviced normally.
- Abort: dmem_stb_i drops after 1 grant cycle -> mem_cyc_o=0 the next cycle, no ack, a pending imem request is granted afterwards.
- Async reset mid-GNT_D: rst_in=0 between clock edges -> mem_cyc_o, mem_we_o, acks and tout_o go to 0 immediately, state IDLE, first grant after release goes to imem.
